branch_decode: RTL and testbench
================================

BRANCH_DECODE -- requirements
Module: branch_decode

Interface
REQ-001 Parameter IW, default 9: instruction word width.
REQ-002 Parameter LUT_DEPTH, default 8: entries in the branch-target lookup table, indexed by Instr[2:0].
REQ-003 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 Init_n  input  1  reset, asynchronous, active-low.
REQ-005 PC  input  16  current program counter from the fetch unit.
REQ-006 Mem_req  output  1  instruction memory read request.
REQ-007 Mem_addr  output  16  instruction memory read address.
REQ-008 Mem_valid  input  1  read data valid; qualified only by Mem_req=1.
REQ-009 Mem_rdata  input  IW  instruction word returned by memory.
REQ-010 Stall  input  1  datapath back-pressure; holds the current instruction.
REQ-011 Lut_we, Lut_waddr[2:0], Lut_wdata[15:0]  inputs  target-table write port.
REQ-012 Instr  output  IW  registered instruction presented to the datapath.
REQ-013 Instr_valid  output  1  Instr is valid this cycle.
REQ-014 Advance  output  1  one-cycle strobe permitting the fetch unit to update PC.
REQ-015 Branch_abs, Branch_rel_z, Branch_rel_nz  outputs  1 each  branch controls to the fetch unit.
REQ-016 Target  output  16  branch target or offset to the fetch unit.
REQ-017 Halt  output  1  sticky program-halt flag.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, REQ, DECODE and HALT.
REQ-019 IDLE SHALL move to REQ on the first clock edge after Init_n deasserts.
REQ-020 REQ behaviour:
- Mem_req=1 and Mem_addr=PC.
- On an edge where Mem_valid=1, Mem_rdata SHALL be captured into Instr and the FSM SHALL move to DECODE.
- Otherwise the FSM SHALL remain in REQ with Mem_req held at 1.
REQ-021 Outside REQ, Mem_req=0 and Mem_addr=0, and Mem_valid SHALL be ignored.
REQ-022 In DECODE, Instr_valid SHALL be 1.
REQ-023 In DECODE with Stall=1, the FSM SHALL hold state and Instr, with Advance and all Branch_* outputs at 0.
REQ-024 In DECODE with Stall=0 and a non-halt instruction:
- Advance=1 for exactly that cycle.
- Branch_* and Target are driven combinationally from Instr in the same cycle.
- Next state is REQ.
REQ-025 Decode on Instr[8:6]:
- 101 gives Branch_abs.
- 110 gives Branch_rel_z.
- 111 gives Branch_rel_nz.
- Every other opcode gives no Branch_* assertion.
- At most one Branch_* output is ever 1.
REQ-026 Target SHALL equal LUT[Instr[2:0]] when any Branch_* output is 1, and 0 otherwise.
REQ-027 Instr = 9'b100_000000 SHALL be HALT:
- In DECODE with Stall=0, Advance=0 and no Branch_* output is asserted.
- The next state is HALT.
REQ-028 In HALT, Halt=1, and all other outputs except Instr SHALL be 0 until reset.
REQ-029 LUT write behaviour:
- A write with Lut_we=1 takes effect at the clock edge.
- A same-cycle decode read of the same index SHALL return the pre-write value.
REQ-030 Minimum throughput is one instruction per 2 cycles (REQ with Mem_valid, then DECODE); Mem_valid latency is unbounded.
REQ-031 Branch condition evaluation (ALU_zero) is out of scope; this block only classifies the branch and supplies Target.

Reset
REQ-032 Init_n=0 SHALL asynchronously force:
- state IDLE
- Mem_req=0, Mem_addr=0
- Instr=0, Instr_valid=0
- Advance=0, all Branch_* = 0, Target=0
- Halt=0
- all LUT entries = 0
REQ-033 Reset asserted in REQ or DECODE SHALL abandon the pending read or instruction; a Mem_valid arriving after reset SHALL be ignored unless Mem_req=1.

Verification
REQ-034 Reset then PC=0x0000, Mem_valid on the 1st REQ cycle with Mem_rdata=9'h005 -> Mem_req=1/Mem_addr=0 for 1 cycle, next cycle Instr=9'h005, Instr_valid=1, Advance=1, Branch_*=0, Target=0.
REQ-035 LUT[3]=16'h0010 written, then Mem_rdata=9'b110_000_011 -> in DECODE: Branch_rel_z=1, Target=16'h0010, Advance=1.
REQ-036 Mem_valid delayed 5 cycles -> Mem_req held at 1 for 5 cycles with Mem_addr=PC stable; Advance stays 0 throughout.
REQ-037 Stall=1 for 3 cycles in DECODE with Instr=9'b101_000_001 -> Branch_abs=0 and Advance=0 for 3 cycles, then Branch_abs=1 and Advance=1 for 1 cycle.
REQ-038 HALT instruction fetched -> no Advance; Halt=1 from the next cycle; Mem_valid pulses are ignored; Halt stays 1 until Init_n=0.
REQ-039 Init_n pulled low mid-REQ -> Mem_req=0 immediately (asynchronously); after release, the FSM goes IDLE then REQ.

Source files
------------

// File: rtl/branch_decode.sv
// Instruction fetch/decode front end: fetches one word per request, classifies branches
// and supplies the branch target from a small writable lookup table.
module branch_decode #(
    parameter int unsigned IW        = 9,
    parameter int unsigned LUT_DEPTH = 8
) (
    input  logic          CLK,
    input  logic          Init_n,
    input  logic [15:0]   PC,
    output logic          Mem_req,
    output logic [15:0]   Mem_addr,
    input  logic          Mem_valid,
    input  logic [IW-1:0] Mem_rdata,
    input  logic          Stall,
    input  logic          Lut_we,
    input  logic [2:0]    Lut_waddr,
    input  logic [15:0]   Lut_wdata,
    output logic [IW-1:0] Instr,
    output logic          Instr_valid,
    output logic          Advance,
    output logic          Branch_abs,
    output logic          Branch_rel_z,
    output logic          Branch_rel_nz,
    output logic [15:0]   Target,
    output logic          Halt
);

    typedef enum logic [1:0] {StIdle, StReq, StDecode, StHalt} state_e;

    localparam logic [IW-1:0] HaltInstr = IW'(9'b100_000000);

    state_e        state_q, state_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [15:0]   lut_q [LUT_DEPTH];
    logic [2:0]    opcode;
    logic          is_halt;
    logic          branch_any;

    assign opcode  = instr_q[8:6];
    assign is_halt = (instr_q == HaltInstr);
    assign Instr   = instr_q;

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state_q <= StIdle;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Decode reads the registered table, so a same-edge write is seen only next cycle.
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (Lut_we) begin
            lut_q[Lut_waddr] <= Lut_wdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        Mem_req       = 1'b0;
        Mem_addr      = '0;
        Instr_valid   = 1'b0;
        Advance       = 1'b0;
        Branch_abs    = 1'b0;
        Branch_rel_z  = 1'b0;
        Branch_rel_nz = 1'b0;
        Halt          = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                Mem_req  = 1'b1;
                Mem_addr = PC;
                if (Mem_valid) begin
                    instr_d = Mem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                Instr_valid = 1'b1;
                if (!Stall) begin
                    if (is_halt) begin
                        state_d = StHalt;
                    end else begin
                        Advance       = 1'b1;
                        Branch_abs    = (opcode == 3'b101);
                        Branch_rel_z  = (opcode == 3'b110);
                        Branch_rel_nz = (opcode == 3'b111);
                        state_d       = StReq;
                    end
                end
            end
            StHalt: begin
                Halt = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign branch_any = Branch_abs | Branch_rel_z | Branch_rel_nz;
    assign Target     = branch_any ? lut_q[instr_q[2:0]] : 16'h0000;

endmodule

// File: tb/tb_branch_decode.sv
// Randomized scoreboard bench for branch_decode: stimulus pushes predicted decode results,
// a negedge monitor pops them whenever the DUT presents a completed decode.
module tb_branch_decode;

    logic        CLK = 1'b0;
    logic        Init_n = 1'b1;
    logic [15:0] PC = '0;
    logic        Mem_req;
    logic [15:0] Mem_addr;
    logic        Mem_valid = 1'b0;
    logic [8:0]  Mem_rdata = '0;
    logic        Stall = 1'b0;
    logic        Lut_we = 1'b0;
    logic [2:0]  Lut_waddr = '0;
    logic [15:0] Lut_wdata = '0;
    logic [8:0]  Instr;
    logic        Instr_valid;
    logic        Advance;
    logic        Branch_abs;
    logic        Branch_rel_z;
    logic        Branch_rel_nz;
    logic [15:0] Target;
    logic        Halt;

    branch_decode #(.IW(9), .LUT_DEPTH(8)) dut (
        .CLK          (CLK),
        .Init_n       (Init_n),
        .PC           (PC),
        .Mem_req      (Mem_req),
        .Mem_addr     (Mem_addr),
        .Mem_valid    (Mem_valid),
        .Mem_rdata    (Mem_rdata),
        .Stall        (Stall),
        .Lut_we       (Lut_we),
        .Lut_waddr    (Lut_waddr),
        .Lut_wdata    (Lut_wdata),
        .Instr        (Instr),
        .Instr_valid  (Instr_valid),
        .Advance      (Advance),
        .Branch_abs   (Branch_abs),
        .Branch_rel_z (Branch_rel_z),
        .Branch_rel_nz(Branch_rel_nz),
        .Target       (Target),
        .Halt         (Halt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [8:0]  instr;
        logic        adv;
        logic [2:0]  br;      // {abs, rel_z, rel_nz}
        logic [15:0] tgt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] lut_m [8];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: opcode classes straight from the instruction-set rules.
    function automatic exp_t model(input logic [8:0] ins);
        exp_t e;
        logic [2:0] op;
        op      = ins[8:6];
        e.instr = ins;
        e.adv   = (ins != 9'h100);
        e.br    = {op == 3'd5, op == 3'd6, op == 3'd7};
        e.tgt   = (e.br != 3'b000) ? lut_m[ins[2:0]] : 16'h0000;
        return e;
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (Init_n === 1'b1 && Instr_valid === 1'b1) begin
            if (Stall) begin
                chk("stall_adv", 32'(Advance), 32'd0);
                chk("stall_br", 32'({Branch_abs, Branch_rel_z, Branch_rel_nz}), 32'd0);
                chk("stall_tgt", 32'(Target), 32'd0);
                if (exp_q.size() > 0) chk("stall_instr", 32'(Instr), 32'(exp_q[0].instr));
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_decode: got instr %h, expected no decode", Instr);
            end else begin
                e = exp_q.pop_front();
                chk("dec_instr", 32'(Instr), 32'(e.instr));
                chk("dec_adv", 32'(Advance), 32'(e.adv));
                chk("dec_br", 32'({Branch_abs, Branch_rel_z, Branch_rel_nz}), 32'(e.br));
                chk("dec_tgt", 32'(Target), 32'(e.tgt));
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < 8; i++) lut_m[i] = 16'h0000;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_req"}, 32'(Mem_req), 32'd0);
        chk({nm, "_addr"}, 32'(Mem_addr), 32'd0);
        chk({nm, "_ivalid"}, 32'(Instr_valid), 32'd0);
        chk({nm, "_adv"}, 32'(Advance), 32'd0);
        chk({nm, "_br"}, 32'({Branch_abs, Branch_rel_z, Branch_rel_nz}), 32'd0);
        chk({nm, "_tgt"}, 32'(Target), 32'd0);
    endtask

    // Ends #1 after the edge that enters the first REQ cycle.
    task automatic do_reset();
        Init_n    = 1'b0;
        Mem_valid = 1'b0;
        Stall     = 1'b0;
        Lut_we    = 1'b0;
        clear_model();
        repeat (2) @(negedge CLK);
        chk_quiet("rst");
        chk("rst_instr", 32'(Instr), 32'd0);
        chk("rst_halt", 32'(Halt), 32'd0);
        @(posedge CLK); #1;
        Init_n = 1'b1;
        @(negedge CLK);
        chk("idle_req", 32'(Mem_req), 32'd0);
        @(posedge CLK); #1;
    endtask

    task automatic lut_write(input logic [2:0] a, input logic [15:0] d);
        Lut_we    = 1'b1;
        Lut_waddr = a;
        Lut_wdata = d;
        @(negedge CLK);
        chk("wr_in_req", 32'(Mem_req), 32'd1);
        @(posedge CLK); #1;
        Lut_we   = 1'b0;
        lut_m[a] = d;
    endtask

    // Starts and ends #1 after an edge in REQ (or HALT after a halt instruction).
    task automatic fetch(input logic [8:0] ins, input logic [15:0] pc, input int dly,
                         input int stl, input bit wr_dec, input logic [15:0] wdat);
        PC = pc;
        for (int i = 0; i < dly; i++) begin
            @(negedge CLK);
            chk("wait_req", 32'(Mem_req), 32'd1);
            chk("wait_addr", 32'(Mem_addr), 32'(pc));
            chk("wait_adv", 32'(Advance), 32'd0);
            chk("wait_ivalid", 32'(Instr_valid), 32'd0);
            @(posedge CLK); #1;
        end
        Mem_valid = 1'b1;
        Mem_rdata = ins;
        exp_q.push_back(model(ins));
        @(negedge CLK);
        chk("fetch_req", 32'(Mem_req), 32'd1);
        chk("fetch_addr", 32'(Mem_addr), 32'(pc));
        @(posedge CLK); #1;
        Mem_rdata = 9'($urandom);
        for (int i = 0; i < stl; i++) begin
            Stall     = 1'b1;
            Mem_valid = 1'($urandom);
            @(posedge CLK); #1;
        end
        Stall     = 1'b0;
        Mem_valid = 1'($urandom);
        if (wr_dec) begin
            Lut_we    = 1'b1;
            Lut_waddr = ins[2:0];
            Lut_wdata = wdat;
        end
        @(negedge CLK);
        chk("dec_memreq", 32'(Mem_req), 32'd0);
        @(posedge CLK); #1;
        Mem_valid = 1'b0;
        Lut_we    = 1'b0;
        if (wr_dec) lut_m[ins[2:0]] = wdat;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] ins;
        #2;
        do_reset();

        fetch(9'h005, 16'h0000, 0, 0, 1'b0, 16'h0);
        lut_write(3'd3, 16'h0010);
        fetch(9'h183, 16'h0002, 0, 0, 1'b0, 16'h0);
        fetch(9'h0A7, 16'h0010, 5, 0, 1'b0, 16'h0);
        lut_write(3'd1, 16'hBEEF);
        fetch(9'h141, 16'h0020, 1, 3, 1'b0, 16'h0);
        // Write in the decode cycle of the same index: decode still sees 0xBEEF.
        fetch(9'h1C1, 16'h0030, 0, 0, 1'b1, 16'h1234);
        fetch(9'h141, 16'h0031, 0, 0, 1'b0, 16'h0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) lut_write(3'($urandom), 16'($urandom));
            ins = 9'($urandom);
            if (ins == 9'h100) ins = 9'h101;
            fetch(ins, 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        // Asynchronous reset in the middle of a REQ wait.
        PC = 16'h1234;
        @(negedge CLK);
        chk("pre_rst_req", 32'(Mem_req), 32'd1);
        #2;
        Init_n = 1'b0;
        clear_model();
        #1;
        chk("async_req", 32'(Mem_req), 32'd0);
        chk("async_addr", 32'(Mem_addr), 32'd0);
        chk("async_instr", 32'(Instr), 32'd0);
        Mem_valid = 1'b1;
        Mem_rdata = 9'h1FF;
        @(posedge CLK); #1;
        Init_n = 1'b1;
        @(negedge CLK);
        chk("post_rst_idle_req", 32'(Mem_req), 32'd0);
        chk("post_rst_idle_iv", 32'(Instr_valid), 32'd0);
        @(posedge CLK); #1;
        Mem_valid = 1'b0;
        @(negedge CLK);
        chk("post_rst_req", 32'(Mem_req), 32'd1);
        chk("post_rst_instr", 32'(Instr), 32'd0);
        chk("post_rst_iv", 32'(Instr_valid), 32'd0);
        @(posedge CLK); #1;
        fetch(9'h183, 16'h0040, 0, 0, 1'b0, 16'h0);

        // Halt is sticky and ignores everything but reset.
        fetch(9'h100, 16'h0050, 1, 1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            Mem_valid = 1'($urandom);
            Stall     = 1'($urandom);
            Mem_rdata = 9'($urandom);
            PC        = 16'($urandom);
            @(negedge CLK);
            chk("halt_flag", 32'(Halt), 32'd1);
            chk_quiet("halt");
            chk("halt_instr", 32'(Instr), 32'h100);
            @(posedge CLK); #1;
        end
        Mem_valid = 1'b0;
        Stall     = 1'b0;
        do_reset();
        fetch(9'h1E3, 16'h0060, 2, 1, 1'b0, 16'h0);

        @(negedge CLK);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
